// File: rtl/layer_scheduler.sv
// layer_scheduler
// Runs one fully-connected layer on a single time-shared MAC. For each neuron n
// it fetches N_IN input/weight pairs, accumulates the fixed-point products,
// adds the bias, and passes the sum through an external combinational
// activation unit. The result is then offered on a valid/ready output port.
// Input, weight and bias memories sit outside this block and have a
// one-cycle read latency.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   start, abort      begin a layer pass / cancel the pass in progress
//   x_sel / x_data    input-vector read address and returned element
//   w_addr / w_data   weight read address (n*N_IN+i) and returned weight
//   b_addr / b_data   bias read address (n) and returned bias
//   act_z / act_a     pre-activation sum out, activation result in (same cycle)
//   y_valid/y_ready   output handshake; y_idx = neuron, y_data = result
//   busy              high whenever not IDLE
//   done              one-cycle pulse after the last neuron is accepted
module layer_scheduler #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int W     = 8,
  parameter int FRAC  = 4,
  localparam int XW   = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int AW   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int NW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic [XW-1:0]       x_sel,
  input  logic signed [W-1:0] x_data,
  output logic [AW-1:0]       w_addr,
  input  logic signed [W-1:0] w_data,
  output logic [NW-1:0]       b_addr,
  input  logic signed [W-1:0] b_data,
  output logic signed [W-1:0] act_z,
  input  logic signed [W-1:0] act_a,
  output logic                y_valid,
  input  logic                y_ready,
  output logic [NW-1:0]       y_idx,
  output logic signed [W-1:0] y_data,
  output logic                busy,
  output logic                done
);

  // j runs 0..N_IN inclusive, so it needs room for N_IN itself.
  localparam int JW = $clog2(N_IN + 1);

  typedef enum logic [2:0] {IDLE, MAC, BIAS, ACT, OUT} state_t;

  state_t                state;
  state_t                state_next;
  logic [NW-1:0]         n;
  logic [JW-1:0]         j;
  logic signed [W-1:0]   acc;
  logic signed [2*W-1:0] prod_full;
  logic signed [W-1:0]   prod_w;
  logic                  j_last;
  logic                  n_last;
  logic                  hs;

  // Full-width signed product, floor-shifted, then truncated to W bits.
  assign prod_full = w_data * x_data;
  assign prod_w    = W'(prod_full >>> FRAC);

  assign j_last = (j == JW'(N_IN));
  assign n_last = (n == NW'(N_OUT - 1));
  assign hs     = y_valid & y_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides every transition, including start in IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = MAC;
      MAC:  if (j_last) state_next = BIAS;
      BIAS: state_next = ACT;
      ACT:  state_next = OUT;
      OUT:  if (hs) state_next = n_last ? IDLE : MAC;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n       <= '0;
      j       <= '0;
      acc     <= '0;
      y_valid <= 1'b0;
      y_idx   <= '0;
      y_data  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort beats a same-cycle handshake: the element is not consumed.
        y_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              n   <= '0;
              j   <= '0;
              acc <= '0;
            end
          end
          MAC: begin
            // Data requested at j-1 arrives at j, so accumulation lags by one.
            if (j != '0) acc <= acc + prod_w;
            if (!j_last) j <= j + JW'(1);
          end
          BIAS: acc <= acc + b_data;
          ACT: begin
            y_data  <= act_a;
            y_idx   <= n;
            y_valid <= 1'b1;
          end
          OUT: begin
            if (hs) begin
              y_valid <= 1'b0;
              if (n_last) begin
                done <= 1'b1;
              end else begin
                n   <= n + NW'(1);
                acc <= '0;
                j   <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Memory addresses and activation operand are only driven in their own
  // cycles and are zero otherwise.
  always_comb begin
    x_sel  = '0;
    w_addr = '0;
    b_addr = '0;
    act_z  = '0;
    busy   = (state != IDLE);
    if (state == MAC) begin
      if (!j_last) begin
        x_sel  = XW'(j);
        w_addr = AW'(n) * AW'(N_IN) + AW'(j);
      end else begin
        b_addr = n;
      end
    end
    if (state == ACT) act_z = acc;
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// Testbench for layer_scheduler: directed passes with hand-computed results.
// Expected outputs are queued as each pass is started; a separate monitor
// pops and compares on every accepted output element.
module tb_layer_scheduler;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              y_ready = 1'b0;
  logic [0:0]        x_sel;
  logic [1:0]        w_addr;
  logic [0:0]        b_addr;
  logic [0:0]        y_idx;
  logic signed [7:0] x_data, w_data, b_data, act_z, act_a, y_data;
  logic              y_valid, busy, done;

  logic signed [7:0] x_mem [2];
  logic signed [7:0] w_mem [4];
  logic signed [7:0] b_mem [2];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int idx;
    int data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  layer_scheduler #(.N_IN(2), .N_OUT(2), .W(8), .FRAC(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .x_sel   (x_sel),
    .x_data  (x_data),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .act_z   (act_z),
    .act_a   (act_a),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_idx   (y_idx),
    .y_data  (y_data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Identity activation; memories with one-cycle registered read.
  assign act_a = act_z;
  always @(posedge clk) begin
    x_data <= x_mem[x_sel];
    w_data <= w_mem[w_addr];
    b_data <= b_mem[b_addr];
  end

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: an element counts as accepted on valid&ready unless
  // abort is high in the same cycle.
  always @(negedge clk) begin
    if (rst && y_valid && y_ready && !abort) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got idx=%0d data=%0d expected none", y_idx, y_data);
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn: y_idx=%0d y_data=%0d (exp %0d/%0d)", y_idx, y_data, mon_e.idx, mon_e.data);
        check("y_idx", y_idx, mon_e.idx);
        check("y_data", $signed(y_data), mon_e.data);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_y_valid"}, y_valid, 0);
    check({tag, "_y_idx"}, y_idx, 0);
    check({tag, "_y_data"}, $signed(y_data), 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_x_sel"}, x_sel, 0);
    check({tag, "_w_addr"}, w_addr, 0);
    check({tag, "_b_addr"}, b_addr, 0);
    check({tag, "_act_z"}, $signed(act_z), 0);
  endtask

  // Issue start (called just after a rising edge) and count cycles to done.
  task automatic run_pass(input int limit, output int dcyc, output int dcnt);
    dcyc = -1;
    dcnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (dcyc < 0) dcyc = c;
        dcnt++;
      end
    end
  endtask

  task automatic load_nominal();
    x_mem[0] = 8'sd16;   x_mem[1] = 8'sd32;
    w_mem[0] = -8'sd5;   w_mem[1] = -8'sd15;
    w_mem[2] = 8'sd1;    w_mem[3] = 8'sd2;
    b_mem[0] = -8'sd2;   b_mem[1] = 8'sd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dcyc, dcnt;
    load_nominal();

    // Reset state
    #1 rst = 1'b0;
    #2 check_all_zero("reset");
    #9 rst = 1'b1;
    @(posedge clk); #1;

    // Nominal + full layer: n0 -> -37, n1 -> 5, done 12 cycles after start
    y_ready = 1'b1;
    exp_q.push_back('{0, -37});
    exp_q.push_back('{1, 5});
    dcyc = -1; dcnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("nom_busy", busy, 1);
    check("nom_w_addr_j0", w_addr, 0);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        check("nom_x_sel_j1", x_sel, 1);
        check("nom_w_addr_j1", w_addr, 1);
      end
      if (c == 4) check("nom_act_z_n0", $signed(act_z), -37);
      if (c == 6) check("nom_w_addr_n1j0", w_addr, 2);
      if (c == 8) check("nom_b_addr_n1", b_addr, 1);
      if (done) begin
        if (dcyc < 0) dcyc = c;
        dcnt++;
      end
    end
    check("nom_done_latency", dcyc, 12);
    check("nom_done_pulses", dcnt, 1);
    check("nom_idle_busy", busy, 0);
    check("nom_idle_w_addr", w_addr, 0);

    // Wrap: 127*127 = 16129 >>> 4 = 1008 -> truncates to -16
    w_mem[0] = 8'sd127; w_mem[1] = 8'sd0;
    x_mem[0] = 8'sd127; b_mem[0] = 8'sd0;
    exp_q.push_back('{0, -16});
    exp_q.push_back('{1, 11});   // 127*1>>>4=7, 32*2>>>4=4
    run_pass(16, dcyc, dcnt);
    check("wrap_done_latency", dcyc, 12);
    load_nominal();

    // Back-pressure: y_ready low for 5 OUT cycles
    y_ready = 1'b0;
    exp_q.push_back('{0, -37});
    exp_q.push_back('{1, 5});
    dcyc = -1; dcnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1;
      if (c >= 6 && c <= 10) begin
        check("bp_hold_valid", y_valid, 1);
        check("bp_hold_data", $signed(y_data), -37);
        check("bp_hold_idx", y_idx, 0);
      end
      if (c == 10) y_ready = 1'b1;
      if (c == 11) begin
        check("bp_valid_drop", y_valid, 0);
        check("bp_n1_start", w_addr, 2);
        check("bp_busy", busy, 1);
      end
      if (done) begin
        if (dcyc < 0) dcyc = c;
        dcnt++;
      end
    end
    check("bp_done_latency", dcyc, 17);
    check("bp_done_pulses", dcnt, 1);

    // Abort in MAC j=1
    dcnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 1) abort = 1'b1;
      if (c == 2) begin
        abort = 1'b0;
        check("abort_mac_busy", busy, 0);
        check("abort_mac_valid", y_valid, 0);
      end
      if (done) dcnt++;
    end
    check("abort_mac_no_done", dcnt, 0);

    // Abort together with the OUT handshake
    dcnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin
        check("abort_out_valid_before", y_valid, 1);
        abort = 1'b1;
      end
      if (c == 6) begin
        abort = 1'b0;
        check("abort_out_busy", busy, 0);
        check("abort_out_valid", y_valid, 0);
      end
      if (done) dcnt++;
    end
    check("abort_out_no_done", dcnt, 0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", busy, 0);
    @(posedge clk); #1;
    check("start_abort_idle_busy2", busy, 0);

    // Async reset asserted mid-ACT
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
    end
    check("rst_act_z_before", $signed(act_z), -37);
    #2 rst = 1'b0;
    #1 check_all_zero("midrst");
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", busy, 0);
    exp_q.push_back('{0, -37});
    exp_q.push_back('{1, 5});
    run_pass(16, dcyc, dcnt);
    check("post_rst_done_latency", dcyc, 12);
    check("post_rst_done_pulses", dcnt, 1);

    repeat (3) @(posedge clk);
    #1 check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
